// File: rtl/pie_if.sv
// pie_if: command-bit handshake and PIE envelope output of the forward-link modulator
interface pie_if;
    logic sample_en;
    logic start;
    logic preamble;
    logic in_dat;
    logic in_vld;
    logic in_last;
    logic in_rdy;
    logic out_dat;
    logic out_vld;
    logic busy;
    logic done;
    logic underflow;
    modport master (
        output sample_en, start, preamble, in_dat, in_vld, in_last,
        input  in_rdy, out_dat, out_vld, busy, done, underflow
    );
    modport slave (
        input  sample_en, start, preamble, in_dat, in_vld, in_last,
        output in_rdy, out_dat, out_vld, busy, done, underflow
    );
endinterface

// File: rtl/pie_encoder.sv
// pie_encoder: Gen2 PIE forward-link envelope generator with preamble / frame-sync
module pie_encoder #(
    parameter int TARI  = 25,
    parameter int DATA1 = 45,
    parameter int PW    = 12,
    parameter int DELIM = 50,
    parameter int TRCAL = 150
) (
    input logic  clk,
    input logic  rst,
    pie_if.slave bus
);
    localparam int RTCAL = TARI + DATA1;
    localparam int DT    = DELIM > TRCAL ? DELIM : TRCAL;
    localparam int MAXL  = DT > RTCAL ? DT : RTCAL;
    localparam int CNT_W = $clog2(MAXL + 1);
    typedef enum logic [2:0] {S_IDLE, S_DELIM, S_DATA0, S_RTCAL, S_TRCAL, S_BITS} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pre_q, pre_d, last_q, last_d;
    logic             fetch, fin, udf;
    logic             out_dat_q, out_vld_q, busy_q, done_q, udf_q;
    // state/cnt describe the sample currently on out_dat; cnt counts samples left after it
    assign fetch = bus.sample_en && cnt_q == '0 && (state_q == S_TRCAL ||
                   (state_q == S_RTCAL && !pre_q) || (state_q == S_BITS && !last_q));
    assign bus.in_rdy    = fetch;
    assign bus.out_dat   = out_dat_q;
    assign bus.out_vld   = out_vld_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.underflow = udf_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        last_d  = last_q;
        fin     = 1'b0;
        udf     = 1'b0;
        if (bus.sample_en) begin
            if (state_q == S_IDLE) begin
                if (bus.start) begin
                    state_d = S_DELIM;
                    cnt_d   = CNT_W'(DELIM - 1);
                    pre_d   = bus.preamble;
                end
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (fetch) begin
                state_d = bus.in_vld ? S_BITS : S_IDLE;
                cnt_d   = !bus.in_vld ? '0 : bus.in_dat ? CNT_W'(DATA1 - 1) : CNT_W'(TARI - 1);
                last_d  = bus.in_last;
                udf     = !bus.in_vld;
            end else if (state_q == S_DELIM) begin
                state_d = S_DATA0;
                cnt_d   = CNT_W'(TARI - 1);
            end else if (state_q == S_DATA0) begin
                state_d = S_RTCAL;
                cnt_d   = CNT_W'(RTCAL - 1);
            end else if (state_q == S_RTCAL) begin
                state_d = S_TRCAL;
                cnt_d   = CNT_W'(TRCAL - 1);
            end else begin
                state_d = S_IDLE;
                fin     = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pre_q     <= 1'b0;
            last_q    <= 1'b0;
            out_dat_q <= 1'b1;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            last_q    <= last_d;
            out_dat_q <= state_d == S_IDLE || (state_d != S_DELIM && cnt_d >= CNT_W'(PW));
            out_vld_q <= bus.sample_en;
            busy_q    <= state_d != S_IDLE;
            done_q    <= fin;
            udf_q     <= udf;
        end
    end
endmodule

// File: tb/tb_pie_encoder.sv
// tb_pie_encoder: table-driven and randomized checks of the PIE envelope against a symbol-level model
module tb_pie_encoder;
    localparam int TARI = 25, DATA1 = 45, PW = 12, DELIM = 50, TRCAL = 150;
    localparam int RTCAL = TARI + DATA1;
    typedef struct {
        bit          pre;
        int          n;
        logic [63:0] cmd;
        int          div;
        bit          drop;
        bit          glitch;
        int          exp_end;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pie_if b();
    pie_encoder #(.TARI(TARI), .DATA1(DATA1), .PW(PW), .DELIM(DELIM), .TRCAL(TRCAL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );
    int total = 0, bad = 0;
    bit got[$], expq[$];
    int done_at, udf_at, busy_n, hold_bad;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask
    function automatic void sym(input int len);
        for (int i = 0; i < len; i++) expq.push_back(i < len - PW);
    endfunction
    function automatic int frame_len(input bit pre, input int n, input logic [63:0] cmd);
        int s = DELIM + TARI + RTCAL + (pre ? TRCAL : 0) + 1;
        for (int i = 0; i < n; i++) s += cmd[i] ? DATA1 : TARI;
        return s;
    endfunction
    // Drive one frame and record every out_vld sample from the first delimiter sample onward
    task automatic frame(input bit pre, input int n, input logic [63:0] cmd, input int div,
                         input bit drop, input bit glitch, input int rst_at);
        int idx = 0;
        bit fin = 0, took;
        logic prev;
        got.delete();
        done_at = -1; udf_at = -1; busy_n = 0; hold_bad = 0;
        prev = b.out_dat;
        for (int c = 0; c < 20000 && !fin; c++) begin
            b.sample_en = (c % div) == 0;
            b.start     = c == 0 || (glitch && idx == 1);
            b.preamble  = c == 0 ? pre : !pre;
            b.in_vld    = !drop && idx < n;
            b.in_dat    = cmd[idx % 64];
            b.in_last   = idx == n - 1;
            #2;
            took = b.in_rdy && b.in_vld;
            if (b.in_rdy && !b.sample_en) hold_bad++;
            @(posedge clk);
            #1;
            if (took) idx++;
            if (b.out_vld) begin
                got.push_back(b.out_dat);
                if (b.busy) busy_n++;
                if (b.done) begin done_at = got.size(); fin = 1; end
                if (b.underflow) begin udf_at = got.size(); fin = 1; end
            end else if (b.out_dat !== prev || b.done || b.underflow) hold_bad++;
            prev = b.out_dat;
            if (rst_at > 0 && got.size() == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("midrst_out_dat", b.out_dat, 1);
                chk("midrst_busy", b.busy, 0);
                chk("midrst_pulses", {b.done, b.underflow}, 0);
                fin = 1;
            end
        end
        b.sample_en = 0; b.start = 0; b.in_vld = 0; b.in_last = 0;
        chk("terminated", fin, 1);
    endtask
    task automatic verify(input bit pre, input int n, input logic [63:0] cmd, input bit drop, input int exp_end);
        int mm = 0, k = 0, len = 0, off;
        logic [63:0] word = '0, mask;
        expq.delete();
        repeat (DELIM) expq.push_back(1'b0);
        sym(TARI);
        sym(RTCAL);
        if (pre) sym(TRCAL);
        if (!drop) for (int i = 0; i < n; i++) sym(cmd[i] ? DATA1 : TARI);
        expq.push_back(1'b1);
        chk("wave_len", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) mm++;
        chk("wave_bits", mm, 0);
        chk(drop ? "udf_at" : "done_at", drop ? udf_at : done_at, exp_end);
        chk(drop ? "no_done" : "no_udf", drop ? done_at : udf_at, -1);
        chk("busy_samples", busy_n, exp_end - 1);
        chk("hold", hold_bad, 0);
        if (!drop) begin
            off = DELIM + TARI + RTCAL + (pre ? TRCAL : 0);
            for (int i = off; i + 1 < got.size(); i++) begin
                len++;
                if (!got[i] && got[i + 1]) begin
                    if (k < 64) word[k] = len == DATA1;
                    if (len != DATA1 && len != TARI) mm++;
                    k++;
                    len = 0;
                end
            end
            mask = n == 64 ? '1 : (64'd1 << n) - 1;
            chk("decode_bits", word, cmd & mask);
            chk("decode_count", k, n);
            chk("decode_shape", mm, 0);
        end
    endtask
    initial begin
        vec_t tbl[6];
        logic [63:0] rc;
        bit rp;
        tbl[0] = '{1'b1, 2, 64'h1, 1, 1'b0, 1'b0, 366};
        tbl[1] = '{1'b0, 1, 64'h0, 1, 1'b0, 1'b0, 171};
        tbl[2] = '{1'b1, 2, 64'h1, 1, 1'b1, 1'b0, 296};
        tbl[3] = '{1'b1, 2, 64'h1, 4, 1'b0, 1'b0, 366};
        tbl[4] = '{1'b0, 3, 64'h5, 3, 1'b0, 1'b1, 261};
        tbl[5] = '{1'b0, 2, 64'h3, 1, 1'b1, 1'b0, 146};
        b.sample_en = 0; b.start = 0; b.preamble = 0; b.in_dat = 0; b.in_vld = 0; b.in_last = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_dat", b.out_dat, 1);
        chk("reset_out_vld", b.out_vld, 0);
        chk("reset_busy", b.busy, 0);
        chk("reset_done", b.done, 0);
        chk("reset_underflow", b.underflow, 0);
        b.sample_en = 1;
        #1;
        chk("reset_in_rdy", b.in_rdy, 0);
        b.sample_en = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            frame(tbl[i].pre, tbl[i].n, tbl[i].cmd, tbl[i].div, tbl[i].drop, tbl[i].glitch, 0);
            verify(tbl[i].pre, tbl[i].n, tbl[i].cmd, tbl[i].drop, tbl[i].exp_end);
            repeat (3) @(posedge clk);
            #1;
        end
        frame(1'b1, 2, 64'h1, 1, 1'b0, 1'b0, 100);
        repeat (2) @(posedge clk);
        #1;
        frame(1'b1, 2, 64'h1, 1, 1'b0, 1'b0, 0);
        verify(1'b1, 2, 64'h1, 1'b0, 366);
        for (int r = 0; r < 3; r++) begin
            rc = {$urandom, $urandom};
            rp = 1'($urandom_range(0, 1));
            repeat (2) @(posedge clk);
            #1;
            frame(rp, 64, rc, $urandom_range(1, 3), 1'b0, 1'($urandom_range(0, 1)), 0);
            verify(rp, 64, rc, 1'b0, frame_len(rp, 64, rc));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
